// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter sharing one bit-serial 4-bit ALU between two requesters.
// One operation in flight at a time; illegal opcodes and a silent ALU produce an error response.
module alu_rr_scheduler #(
  parameter int TIMEOUT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_c,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_cf,
  input  logic       alu_done,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_c,
  output logic       rsp_zf,
  output logic       rsp_sf,
  output logic       rsp_cf,
  output logic       rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] TO_LIM = 4'(TIMEOUT);

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  state_t     state, state_nxt;
  logic       rr_last, rr_last_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] cnt_inc;
  logic       gnt0, gnt1, accept, busy;
  logic [2:0] sel_op;
  logic [2:0] op_p0;
  logic [3:0] a_p0, b_p0;
  logic       rsp_id_nxt, rsp_zf_nxt, rsp_sf_nxt, rsp_cf_nxt, rsp_err_nxt;
  logic [3:0] rsp_c_nxt;

  // rr_last holds the requester served most recently; on a tie the other one wins.
  always_comb begin
    gnt1 = req1_valid & (~req0_valid | ~rr_last);
    gnt0 = req0_valid & ~gnt1;
  end

  assign req0_ready = reset & (state == IDLE) & gnt0;
  assign req1_ready = reset & (state == IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign sel_op     = gnt1 ? req1_op : req0_op;
  assign cnt_inc    = cnt + 4'd1;

  // ALU sees operands only while an operation is being computed; opcode 0 clears it.
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign alu_op    = busy ? op_p0 : 3'd0;
  assign alu_a     = busy ? a_p0  : 4'd0;
  assign alu_b     = busy ? b_p0  : 4'd0;
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt   = state;
    rr_last_nxt = rr_last;
    cnt_nxt     = cnt;
    rsp_id_nxt  = rsp_id;
    rsp_c_nxt   = rsp_c;
    rsp_zf_nxt  = rsp_zf;
    rsp_sf_nxt  = rsp_sf;
    rsp_cf_nxt  = rsp_cf;
    rsp_err_nxt = rsp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          rr_last_nxt = gnt1;
          rsp_id_nxt  = gnt1;
          if (op_legal(sel_op)) begin
            state_nxt = ISSUE;
          end else begin
            state_nxt   = RESP;
            rsp_err_nxt = 1'b1;
            rsp_c_nxt   = 4'd0;
            rsp_zf_nxt  = 1'b0;
            rsp_sf_nxt  = 1'b0;
            rsp_cf_nxt  = 1'b0;
          end
        end
      end
      ISSUE: begin
        cnt_nxt   = 4'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          state_nxt   = RESP;
          rsp_err_nxt = 1'b0;
          rsp_c_nxt   = alu_c;
          rsp_zf_nxt  = alu_zf;
          rsp_sf_nxt  = alu_sf;
          rsp_cf_nxt  = alu_cf;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == TO_LIM) begin
            state_nxt   = RESP;
            rsp_err_nxt = 1'b1;
            rsp_c_nxt   = 4'd0;
            rsp_zf_nxt  = 1'b0;
            rsp_sf_nxt  = 1'b0;
            rsp_cf_nxt  = 1'b0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      cnt     <= 4'd0;
      rsp_id  <= 1'b0;
      rsp_c   <= 4'd0;
      rsp_zf  <= 1'b0;
      rsp_sf  <= 1'b0;
      rsp_cf  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_last <= rr_last_nxt;
      cnt     <= cnt_nxt;
      rsp_id  <= rsp_id_nxt;
      rsp_c   <= rsp_c_nxt;
      rsp_zf  <= rsp_zf_nxt;
      rsp_sf  <= rsp_sf_nxt;
      rsp_cf  <= rsp_cf_nxt;
      rsp_err <= rsp_err_nxt;
    end
  end

  // Accept stage: operand latches carry no reset, they are only observed while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= sel_op;
      a_p0  <= gnt1 ? req1_a : req0_a;
      b_p0  <= gnt1 ? req1_b : req0_b;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler; the ALU is modelled by hand-driven done/result.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a, req1_b;
  logic [2:0] alu_op;
  logic [3:0] alu_a, alu_b, alu_c;
  logic       alu_zf, alu_sf, alu_cf, alu_done;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_c;
  logic       rsp_zf, rsp_sf, rsp_cf, rsp_err;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.TIMEOUT(12)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf), .alu_done(alu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
    .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .rsp_cf(rsp_cf), .rsp_err(rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rsp_ready = 1'b0; alu_done = 1'b0; alu_c = 4'd0;
    alu_zf = 1'b0; alu_sf = 1'b0; alu_cf = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'd1; req1_b = 4'd1;
    tick(); tick();
    nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      nerr++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    nvec++; if (alu_op !== 3'd0 || alu_a !== 4'd0 || alu_b !== 4'd0) begin
      nerr++; $display("FAIL reset_alu: got op=%0d a=%0d b=%0d want 0 0 0", alu_op, alu_a, alu_b); end
    nvec++; if (rsp_valid !== 1'b0 || rsp_c !== 4'd0 || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
      nerr++; $display("FAIL reset_rsp: got v=%b c=%0d err=%b id=%b want all 0", rsp_valid, rsp_c, rsp_err, rsp_id); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd3; req0_b = 4'd5;
    #1;
    nvec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      nerr++; $display("FAIL add_grant: got %b%b want 10", req0_ready, req1_ready); end
    tick();
    req0_valid = 1'b0;
    nvec++; if (alu_op !== 3'd2 || alu_a !== 4'd3 || alu_b !== 4'd5) begin
      nerr++; $display("FAIL add_issue: got op=%0d a=%0d b=%0d want 2 3 5", alu_op, alu_a, alu_b); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      nvec++; if (rsp_valid !== 1'b0 || alu_op !== 3'd2) begin
        nerr++; $display("FAIL add_wait%0d: got v=%b op=%0d want 0 2", i, rsp_valid, alu_op); end
    end
    alu_done = 1'b1; alu_c = 4'd8; alu_sf = 1'b1; alu_zf = 1'b0; alu_cf = 1'b0;
    tick();
    alu_done = 1'b0; alu_c = 4'd0; alu_sf = 1'b0;
    nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_c !== 4'd8 || rsp_sf !== 1'b1 ||
                rsp_zf !== 1'b0 || rsp_cf !== 1'b0 || rsp_err !== 1'b0) begin
      nerr++; $display("FAIL add_rsp: got v=%b id=%b c=%0d z=%b s=%b c=%b e=%b want 1 0 8 0 1 0 0",
                       rsp_valid, rsp_id, rsp_c, rsp_zf, rsp_sf, rsp_cf, rsp_err); end
    nvec++; if (alu_op !== 3'd0) begin
      nerr++; $display("FAIL add_resp_op: got %0d want 0", alu_op); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    nvec++; if (rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL add_done: rsp_valid got %b want 0", rsp_valid); end
  endtask

  // Last served was req0, so alternation starts with req1.
  task automatic test_rr();
    logic [1:0] want;
    logic       exp_id;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 4'd0; req1_b = 4'd0;
    exp_id = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      want = exp_id ? 2'b01 : 2'b10;
      nvec++; if ({req0_ready, req1_ready} !== want) begin
        nerr++; $display("FAIL rr_grant%0d: got %b want %b", t, {req0_ready, req1_ready}, want); end
      tick();
      nvec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        nerr++; $display("FAIL rr_busy_ready%0d: got %b%b want 00", t, req0_ready, req1_ready); end
      tick();
      alu_done = 1'b1; alu_c = 4'hF;
      tick();
      alu_done = 1'b0;
      nvec++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_c !== 4'hF) begin
        nerr++; $display("FAIL rr_rsp%0d: got v=%b id=%b c=%0h want 1 %b f", t, rsp_valid, rsp_id, rsp_c, exp_id); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_id = ~exp_id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_illegal();
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 4'd9; req1_b = 4'd9;
    #1;
    nvec++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      nerr++; $display("FAIL ill_grant: got %b%b want 01", req0_ready, req1_ready); end
    tick();
    req1_valid = 1'b0;
    nvec++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b1 || rsp_c !== 4'd0) begin
      nerr++; $display("FAIL ill_rsp: got v=%b id=%b err=%b c=%0d want 1 1 1 0", rsp_valid, rsp_id, rsp_err, rsp_c); end
    nvec++; if (alu_op !== 3'd0) begin
      nerr++; $display("FAIL ill_aluop: got %0d want 0", alu_op); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    nvec++; if (rsp_valid !== 1'b0 || alu_op !== 3'd0) begin
      nerr++; $display("FAIL ill_done: got v=%b op=%0d want 0 0", rsp_valid, alu_op); end
  endtask

  task automatic test_timeout();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 4'd2; req0_b = 4'd7;
    tick();
    req0_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      nvec++; if (rsp_valid !== 1'b0 || alu_op !== 3'd4 || alu_a !== 4'd2 || alu_b !== 4'd7) begin
        nerr++; $display("FAIL to_wait%0d: got v=%b op=%0d a=%0d b=%0d want 0 4 2 7", i, rsp_valid, alu_op, alu_a, alu_b); end
    end
    tick();
    nvec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_c !== 4'd0 || rsp_id !== 1'b0 ||
                {rsp_zf, rsp_sf, rsp_cf} !== 3'b000) begin
      nerr++; $display("FAIL to_rsp: got v=%b err=%b c=%0d id=%b f=%b%b%b want 1 1 0 0 000",
                       rsp_valid, rsp_err, rsp_c, rsp_id, rsp_zf, rsp_sf, rsp_cf); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd0;
    #1;
    nvec++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL to_idle: got rdy=%b v=%b want 1 0", req1_ready, rsp_valid); end
    req1_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd1; req0_b = 4'd1;
    tick();
    req0_valid = 1'b0;
    tick();
    alu_done = 1'b1; alu_c = 4'd2; alu_cf = 1'b1;
    tick();
    alu_done = 1'b0; alu_c = 4'd0; alu_cf = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd3; req1_a = 4'd5; req1_b = 4'd5;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++; if (rsp_valid !== 1'b1 || rsp_c !== 4'd2 || rsp_cf !== 1'b1 || rsp_id !== 1'b0 || req1_ready !== 1'b0) begin
        nerr++; $display("FAIL bp_hold%0d: got v=%b c=%0d cf=%b id=%b r1=%b want 1 2 1 0 0",
                         i, rsp_valid, rsp_c, rsp_cf, rsp_id, req1_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    nvec++; if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL bp_release: got r1=%b v=%b want 1 0", req1_ready, rsp_valid); end
    tick();
    req1_valid = 1'b0;
    nvec++; if (alu_op !== 3'd3 || alu_a !== 4'd5) begin
      nerr++; $display("FAIL bp_next_issue: got op=%0d a=%0d want 3 5", alu_op, alu_a); end
    tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // req0 served last before reset: only a restored pointer grants req0 on the tie.
  task automatic test_reset_in_wait();
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd4; req0_b = 4'd4;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    nvec++; if (alu_op !== 3'd2) begin
      nerr++; $display("FAIL rw_inwait: got op=%0d want 2", alu_op); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    nvec++; if (alu_op !== 3'd0 || rsp_valid !== 1'b0) begin
      nerr++; $display("FAIL rw_cleared: got op=%0d v=%b want 0 0", alu_op, rsp_valid); end
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    nvec++; if (rsp_valid !== 1'b0 || alu_op !== 3'd0) begin
      nerr++; $display("FAIL rw_noresp: got v=%b op=%0d want 0 0", rsp_valid, alu_op); end
    req0_valid = 1'b1; req0_op = 3'd1;
    req1_valid = 1'b1; req1_op = 3'd1;
    #1;
    nvec++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      nerr++; $display("FAIL rw_first_grant: got %b%b want 10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_rr();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
